// File: rtl/mouse_proximity_scheduler_pkg.sv
// Shared types and constants for the mouse proximity sweep.
package mouse_proximity_scheduler_pkg;

  localparam int unsigned Q_W             = 32;
  localparam int unsigned FRAC_BITS       = 12;
  localparam int unsigned CLOSE_RADIUS_PX = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_REQ,
    S_WAIT,
    S_EVAL,
    S_EMIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic signed [Q_W-1:0] x;
    logic signed [Q_W-1:0] y;
  } pos_t;

  // One axis: integer part of |obj - ref| strictly below the radius.
  function automatic logic axis_close(input logic signed [Q_W-1:0] p_obj,
                                      input logic signed [Q_W-1:0] p_ref);
    logic signed [Q_W:0] d;
    logic        [Q_W:0] m;
    d = {p_obj[Q_W-1], p_obj} - {p_ref[Q_W-1], p_ref};
    m = d[Q_W] ? (Q_W+1)'(-d) : (Q_W+1)'(d);
    return (m >> FRAC_BITS) < (Q_W+1)'(CLOSE_RADIUS_PX);
  endfunction

endpackage

// File: rtl/mouse_proximity_scheduler_if.sv
// Frame, object-store and result signals of the proximity scheduler.
interface mouse_proximity_scheduler_if #(
  parameter int unsigned IDX_W = 4
) ();

  logic              frame_start;
  logic [31:0]       x_mouse;
  logic [31:0]       y_mouse;
  logic              obj_rd_req;
  logic [IDX_W-1:0]  obj_rd_idx;
  logic              obj_rd_valid;
  logic [31:0]       obj_x;
  logic [31:0]       obj_y;
  logic              res_valid;
  logic              res_ready;
  logic [IDX_W-1:0]  res_idx;
  logic              res_close;
  logic              res_dir;
  logic              busy;
  logic              sweep_done;
  logic [IDX_W:0]    close_count;

  modport master (
    input  frame_start, x_mouse, y_mouse, obj_rd_valid, obj_x, obj_y, res_ready,
    output obj_rd_req, obj_rd_idx, res_valid, res_idx, res_close, res_dir,
           busy, sweep_done, close_count
  );

  modport slave (
    output frame_start, x_mouse, y_mouse, obj_rd_valid, obj_x, obj_y, res_ready,
    input  obj_rd_req, obj_rd_idx, res_valid, res_idx, res_close, res_dir,
           busy, sweep_done, close_count
  );

endinterface

// File: rtl/mouse_distance_checker.sv
// Combinational closeness / flee-direction check of one object against the mouse.
module mouse_distance_checker
  import mouse_proximity_scheduler_pkg::*;
(
  input  pos_t i_mouse,
  input  pos_t i_obj,
  output logic o_close_c,
  output logic o_dir_c
);

  assign o_close_c = axis_close(i_obj.x, i_mouse.x) && axis_close(i_obj.y, i_mouse.y);
  // Object strictly left of the mouse.
  assign o_dir_c   = $signed(i_obj.x) < $signed(i_mouse.x);

endmodule

// File: rtl/mouse_proximity_scheduler.sv
// Sweeps all objects once per frame through one shared distance checker.
module mouse_proximity_scheduler
  import mouse_proximity_scheduler_pkg::*;
#(
  parameter int unsigned N_OBJ = 16,
  parameter int unsigned IDX_W = $clog2(N_OBJ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mouse_proximity_scheduler_if.master  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  state_e           r_state, w_next;
  pos_t             r_mouse, r_obj;
  logic [IDX_W-1:0] r_idx, r_res_idx;
  logic [IDX_W:0]   r_cnt, r_close_count;
  logic             r_rd_req, r_res_valid, r_res_close, r_res_dir, r_busy, r_sweep_done;
  logic             w_close, w_dir, w_last;

  mouse_distance_checker u_checker (
    .i_mouse   (r_mouse),
    .i_obj     (r_obj),
    .o_close_c (w_close),
    .o_dir_c   (w_dir)
  );

  assign w_last = (r_idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; starts while busy are dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.frame_start) w_next = S_LATCH;
      S_LATCH: w_next = S_REQ;
      S_REQ:   w_next = S_WAIT;
      S_WAIT:  if (bus.obj_rd_valid) w_next = S_EVAL;
      S_EVAL:  w_next = S_EMIT;
      S_EMIT:  if (bus.res_ready) w_next = w_last ? S_DONE : S_REQ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; strobes are aligned with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mouse       <= '0;
      r_obj         <= '0;
      r_idx         <= '0;
      r_res_idx     <= '0;
      r_cnt         <= '0;
      r_close_count <= '0;
      r_rd_req      <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_close   <= 1'b0;
      r_res_dir     <= 1'b0;
      r_busy        <= 1'b0;
      r_sweep_done  <= 1'b0;
    end else begin
      r_rd_req     <= (w_next == S_REQ);
      r_res_valid  <= (w_next == S_EMIT);
      r_sweep_done <= (w_next == S_DONE);
      r_busy       <= (w_next != S_IDLE);
      case (r_state)
        S_LATCH: begin
          r_mouse <= '{x: bus.x_mouse, y: bus.y_mouse};
          r_idx   <= '0;
          r_cnt   <= '0;
        end
        S_WAIT: if (bus.obj_rd_valid) r_obj <= '{x: bus.obj_x, y: bus.obj_y};
        S_EVAL: begin
          r_res_idx   <= r_idx;
          r_res_close <= w_close;
          r_res_dir   <= w_dir;
        end
        S_EMIT: if (bus.res_ready) begin
          r_cnt <= r_cnt + (IDX_W+1)'(r_res_close);
          if (!w_last) r_idx <= r_idx + IDX_W'(1);
        end
        S_DONE:  r_close_count <= r_cnt;
        default: ;
      endcase
    end
  end

  assign bus.obj_rd_req  = r_rd_req;
  assign bus.obj_rd_idx  = r_idx;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_idx     = r_res_idx;
  assign bus.res_close   = r_res_close;
  assign bus.res_dir     = r_res_dir;
  assign bus.busy        = r_busy;
  assign bus.sweep_done  = r_sweep_done;
  assign bus.close_count = r_close_count;

endmodule

// File: tb/tb_mouse_proximity_scheduler.sv
// Self-checking bench: object-store model, result scoreboard and sweep sequences.
module tb_mouse_proximity_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mouse_proximity_scheduler_if #(.IDX_W(IW)) bus ();

  mouse_proximity_scheduler #(.N_OBJ(N), .IDX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { real ox; real oy; logic c; logic d; } vec_t;
  typedef struct { int idx; logic c; logic d; } sb_t;

  vec_t tbl [5][N];
  real  mx  [5];
  real  my  [5];

  int n_chk = 0;
  int n_fail = 0;

  logic signed [31:0] mem_x [N];
  logic signed [31:0] mem_y [N];
  logic               exp_c [N];
  logic               exp_d [N];
  int  lat = 1;
  int  pend_cnt = 0;
  int  pend_idx = 0;
  int  req_seq = 0;
  sb_t sbq [$];

  int   res_seq = 0;
  int   n_res = 0;
  int   stall_idx = -1;
  int   stall_left = 0;
  logic h_valid = 1'b0;
  logic [IW-1:0] h_idx;
  logic h_c, h_d;

  function automatic logic signed [31:0] q(input real px);
    return $rtoi(px * 4096.0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Object store: answers each read request after 'lat' cycles and pushes the expected result.
  always @(negedge clk) begin
    bus.obj_rd_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.obj_rd_valid = 1'b1;
        bus.obj_x = mem_x[pend_idx];
        bus.obj_y = mem_y[pend_idx];
        sbq.push_back('{pend_idx, exp_c[pend_idx], exp_d[pend_idx]});
      end
    end
    if (rst_n && bus.obj_rd_req === 1'b1) begin
      chk("rd_idx", 64'(bus.obj_rd_idx), 64'(req_seq));
      pend_idx = int'(bus.obj_rd_idx);
      pend_cnt = lat;
      req_seq  = (req_seq + 1) % N;
    end
  end

  // Result consumer: optional stall on one index, stability checks, scoreboard compare.
  always @(negedge clk) begin
    bus.res_ready = 1'b1;
    if (rst_n && bus.res_valid === 1'b1) begin
      if (h_valid) begin
        chk("hold_idx", 64'(bus.res_idx), 64'(h_idx));
        chk("hold_close", 64'(bus.res_close), 64'(h_c));
        chk("hold_dir", 64'(bus.res_dir), 64'(h_d));
      end
      if (int'(bus.res_idx) == stall_idx && stall_left > 0) begin
        if (!h_valid) begin
          h_valid = 1'b1;
          h_idx = bus.res_idx;
          h_c = bus.res_close;
          h_d = bus.res_dir;
        end
        chk("stall_no_req", 64'(bus.obj_rd_req), 64'(0));
        bus.res_ready = 1'b0;
        stall_left--;
      end else begin
        h_valid = 1'b0;
        chk("res_idx", 64'(bus.res_idx), 64'(res_seq));
        if (sbq.size() == 0) begin
          fail_now("scoreboard_empty");
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("res_close", 64'(bus.res_close), 64'(e.c));
          chk("res_dir", 64'(bus.res_dir), 64'(e.d));
        end
        res_seq = (res_seq + 1) % N;
        n_res++;
      end
    end
  end

  task automatic load(input int s);
    for (int i = 0; i < N; i++) begin
      mem_x[i] = q(tbl[s][i].ox);
      mem_y[i] = q(tbl[s][i].oy);
      exp_c[i] = tbl[s][i].c;
      exp_d[i] = tbl[s][i].d;
    end
    bus.x_mouse = q(mx[s]);
    bus.y_mouse = q(my[s]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_req"}, 64'(bus.obj_rd_req), 64'(0));
    chk({tag, "_rd_idx"}, 64'(bus.obj_rd_idx), 64'(0));
    chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'(0));
    chk({tag, "_res_idx"}, 64'(bus.res_idx), 64'(0));
    chk({tag, "_res_close"}, 64'(bus.res_close), 64'(0));
    chk({tag, "_res_dir"}, 64'(bus.res_dir), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_sweep_done"}, 64'(bus.sweep_done), 64'(0));
    chk({tag, "_close_count"}, 64'(bus.close_count), 64'(0));
  endtask

  // One full sweep; cycles counted with the frame_start sampling edge as cycle 1.
  task automatic sweep(input int s, input int l, input int exp_cyc,
                       input bit mid, input int cc_mid, input int exp_cc);
    int cyc;
    load(s);
    lat = l;
    n_res = 0;
    res_seq = 0;
    req_seq = 0;
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    cyc = 1;
    chk("busy_start", 64'(bus.busy), 64'(1));
    while (bus.sweep_done !== 1'b1) begin
      if (cyc >= 200) begin
        fail_now("sweep_timeout");
        break;
      end
      @(negedge clk);
      cyc++;
      bus.frame_start = (mid && cyc == 6);
      if (mid && cyc == 6) bus.x_mouse = q(mx[s] + 30.0);
      if (cc_mid >= 0 && cyc == 8) chk("cc_hold", 64'(bus.close_count), 64'(cc_mid));
    end
    chk("sweep_cycles", 64'(cyc), 64'(exp_cyc));
    chk("n_results", 64'(n_res), 64'(N));
    @(negedge clk);
    chk("done_pulse", 64'(bus.sweep_done), 64'(0));
    chk("busy_after", 64'(bus.busy), 64'(0));
    chk("close_count", 64'(bus.close_count), 64'(exp_cc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.x_mouse = '0;
    bus.y_mouse = '0;

    mx[0] = 100.0;   my[0] = 100.0;
    tbl[0][0] = '{119.99, 100.0, 1'b1, 1'b0};
    tbl[0][1] = '{120.0,  100.0, 1'b0, 1'b0};
    tbl[0][2] = '{80.5,   81.0,  1'b1, 1'b1};
    tbl[0][3] = '{200.0,  100.0, 1'b0, 1'b0};
    mx[1] = -50.0;   my[1] = -50.0;
    tbl[1][0] = '{-45.0, -45.0, 1'b1, 1'b0};
    tbl[1][1] = '{-55.0, -47.0, 1'b1, 1'b1};
    tbl[1][2] = '{-80.0, -50.0, 1'b0, 1'b1};
    tbl[1][3] = '{-50.0, -75.0, 1'b0, 1'b0};
    mx[2] = 300.0;   my[2] = 200.0;
    tbl[2][0] = '{310.0, 205.0, 1'b1, 1'b0};
    tbl[2][1] = '{295.0, 190.0, 1'b1, 1'b1};
    tbl[2][2] = '{330.0, 200.0, 1'b0, 1'b0};
    tbl[2][3] = '{300.0, 219.5, 1'b1, 1'b0};
    mx[3] = 1000.0;  my[3] = 1000.0;
    tbl[3][0] = '{1000.0, 1000.0, 1'b1, 1'b0};
    tbl[3][1] = '{1019.0, 981.0,  1'b1, 1'b0};
    tbl[3][2] = '{985.0,  1010.0, 1'b1, 1'b1};
    tbl[3][3] = '{1001.5, 999.0,  1'b1, 1'b0};
    mx[4] = 1000.0;  my[4] = 1000.0;
    tbl[4][0] = '{0.0,    0.0,    1'b0, 1'b1};
    tbl[4][1] = '{1020.0, 1000.0, 1'b0, 1'b0};
    tbl[4][2] = '{1000.0, 1020.0, 1'b0, 1'b0};
    tbl[4][3] = '{979.0,  1000.0, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Basic sweep with the boundary objects.
    sweep(0, 1, 18, 1'b0, -1, 2);

    // Consumer stalls five cycles on index 2.
    stall_idx = 2;
    stall_left = 5;
    sweep(1, 1, 23, 1'b0, -1, 2);
    chk("stall_consumed", 64'(stall_left), 64'(0));
    stall_idx = -1;

    // Mouse moves and a second start arrives mid-sweep.
    sweep(2, 1, 18, 1'b1, -1, 3);
    repeat (5) @(negedge clk);
    chk("no_queued_start", 64'(bus.busy), 64'(0));

    // All close, then none close with a slower store.
    sweep(3, 1, 18, 1'b0, -1, 4);
    sweep(4, 2, 22, 1'b0, 4, 0);

    // Reset while waiting on index 1.
    sweep(3, 1, 18, 1'b0, -1, 4);
    load(3);
    lat = 3;
    req_seq = 0;
    res_seq = 0;
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    begin
      int g;
      g = 0;
      while (!(bus.obj_rd_req === 1'b1 && bus.obj_rd_idx == IW'(1))) begin
        if (g >= 100) begin
          fail_now("req1_timeout");
          break;
        end
        @(negedge clk);
        g++;
      end
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("late_busy", 64'(bus.busy), 64'(0));
      chk("late_req", 64'(bus.obj_rd_req), 64'(0));
      chk("late_res_valid", 64'(bus.res_valid), 64'(0));
    end
    sbq.delete();
    sweep(3, 1, 18, 1'b0, -1, 4);
    chk("sb_drained", 64'(sbq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
